bus_mem_responder: RTL
======================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the internal memory (depth 2^ADDR_W words, 32 bits each).
REQ-002 Parameter RD_LAT, default 1, number of wait cycles between read capture and data drive (range 0..7).
REQ-003 Parameter CTRL_ADDR, default 5000, bus address reserved for the DMA control register; the responder never claims it.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 address_Bus  input  32  word address presented by the current bus initiator.
REQ-007 Data_Bus  inout  32  shared data bus; the responder drives it only in state DRIVE, otherwise high-Z.
REQ-008 Read  input  1  read strobe from the initiator, sampled on the rising edge.
REQ-009 Write  input  1  write strobe from the initiator, sampled on the rising edge.
REQ-010 Ready  output  1  one-cycle completion pulse for an accepted read or write.
REQ-011 Err  output  1  one-cycle pulse for a rejected request.

Function
REQ-012 Hit = address_Bus[31:ADDR_W]==0 and address_Bus!=CTRL_ADDR; miss otherwise.
REQ-013 FSM states: IDLE, WAIT, DRIVE, WACK; requests are sampled only in IDLE, with one transaction outstanding at most.
REQ-014 IDLE, Read=1, Write=0, hit: latch address; go to WAIT with a counter loaded to RD_LAT; go straight to DRIVE if RD_LAT=0.
REQ-015 WAIT: decrement the counter each cycle; go to DRIVE on the cycle after the counter reaches 0.
REQ-016 DRIVE: drive mem[latched addr] on Data_Bus and assert Ready for exactly one cycle; return to IDLE.
REQ-017 Read latency from the sampling edge to the Ready/data cycle is RD_LAT+1 cycles.
REQ-018 IDLE, Write=1, Read=0, hit: write Data_Bus into mem[address_Bus[ADDR_W-1:0]] on that edge; go to WACK.
REQ-019 WACK: assert Ready for one cycle; return to IDLE; back-to-back writes sustain one write every 2 cycles.
REQ-020 IDLE, Read=1 and Write=1 together: no memory access; Err pulses the next cycle; stay in IDLE.
REQ-021 IDLE, strobe with a miss (including CTRL_ADDR): no access, no Err, no Ready; stay in IDLE.
REQ-022 Strobes arriving in WAIT/DRIVE/WACK are ignored, with no queueing and no Err.
REQ-023 Ready and Err are never asserted in the same cycle.
REQ-024 Read-after-write to the same address returns the newly written data, with no hazard window.

Reset
REQ-025 RST_N low forces IDLE, Ready=0, Err=0, counter=0, and Data_Bus released to high-Z, all immediately and asynchronously.
REQ-026 Memory contents are not cleared by reset; a read in flight is aborted with no Ready.
REQ-027 The first request is sampled on the first rising edge after RST_N goes high.

Structure
REQ-028 State encoding and the CTRL_ADDR default live in the shared bus package, which the DMA also uses.
REQ-029 One sub-module, bus_mem_array (synchronous write, asynchronous read, 2^ADDR_W x 32), is instantiated once.
REQ-030 The tri-state driver is a single continuous assignment gated by state==DRIVE.

Verification
REQ-031 Write 0xDEADBEEF at addr 0x10, then read 0x10 (RD_LAT=1) -> Ready 1 cycle after write; read data + Ready 2 cycles after Read edge.
REQ-032 Read and Write both high at addr 0x20 -> Err pulse next cycle, mem[0x20] unchanged, Data_Bus high-Z.
REQ-033 Write to addr 5000 and to addr 0x100 (ADDR_W=8) -> no Ready, no Err, no memory change.
REQ-034 Read addr 0x05, assert RST_N low in WAIT -> Data_Bus high-Z immediately, no Ready; the next read of 0x05 returns its prior data.
REQ-035 Read with RD_LAT=0 while a second Read is held high -> first Ready 1 cycle after the edge; the second strobe is sampled only after return to IDLE.
REQ-036 Sweep all 256 addresses with write-then-read -> every word matches and Data_Bus is never driven outside DRIVE.

Source files
------------

// File: rtl/bus_mem_responder_pkg.sv
// Shared bus definitions: responder state encoding, reserved control address, hit decode.
// Used by the memory responder and by the DMA that owns the control register.
// Contents: bus_state_e, CTRL_ADDR_DEFAULT, RD_LAT_MAX, addr_hit().
package bus_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        WACK  = 2'd3
    } bus_state_e;

    // Word address of the DMA control register; memory responders never claim it.
    localparam logic [31:0] CTRL_ADDR_DEFAULT = 32'd5000;

    // Largest read wait count the 3-bit latency counter can hold.
    localparam int unsigned RD_LAT_MAX = 7;

    // An address belongs to a responder when it fits in its word space and is
    // not the reserved control register.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input int unsigned addr_w,
                                      input logic [31:0] ctrl_addr);
        return ((addr >> addr_w) == 32'd0) && (addr != ctrl_addr);
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Initiator/responder control bundle of the shared memory bus.
// master: drives address_Bus, Read, Write; samples Ready, Err.
// slave : samples address_Bus, Read, Write; drives Ready, Err.
// The 32-bit data lines are a resolved tri-state net and travel as a separate inout.
interface bus_mem_responder_if;

    logic [31:0] address_Bus;
    logic        Read;
    logic        Write;
    logic        Ready;
    logic        Err;

    modport master (
        output address_Bus,
        output Read,
        output Write,
        input  Ready,
        input  Err
    );

    modport slave (
        input  address_Bus,
        input  Read,
        input  Write,
        output Ready,
        output Err
    );

endinterface

// File: rtl/bus_mem_array.sv
// Purpose: 2^ADDR_W x 32 word storage, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read data follows raddr_i combinationally.
// Backpressure: none; the write port accepts whenever we_i is high. No reset on contents.
module bus_mem_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdat_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdat_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_mem_responder.sv
// Purpose: memory responder on a shared tri-state bus; reads/writes a local bus_mem_array.
// Latency: read data + Ready RD_LAT+1 cycles after the sampling edge; write Ready 1 cycle after.
// Backpressure: one transaction in flight; strobes outside IDLE are dropped, not queued.
// Ports: CLK, RST_N (async active-low), bus (control slave modport), Data_Bus (inout, driven only in DRIVE).
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST_N,
    bus_mem_responder_if.slave bus,
    inout  wire  [31:0]        Data_Bus
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    bus_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ready_q;
    logic              err_q;

    logic              hit;
    logic              mem_we;
    logic [31:0]       rd_dat;

    assign hit = addr_hit(bus.address_Bus, ADDR_W, CTRL_ADDR);

    // Writes commit on the sampling edge itself, so a following read of the
    // same word always sees the new data.
    assign mem_we = RST_N && (state_q == IDLE) && bus.Write && !bus.Read && hit;

    bus_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (bus.address_Bus[ADDR_W-1:0]),
        .wdat_i  (Data_Bus),
        .raddr_i (addr_q),
        .rdat_o  (rd_dat)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Ready and Err are single-cycle pulses raised only on state entry.
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Read && bus.Write) begin
                        // Conflicting strobes on one of our addresses: flag, stay idle.
                        if (hit) begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.Read && hit) begin
                        addr_q <= bus.address_Bus[ADDR_W-1:0];
                        if (RD_LAT_C == 3'd0) begin
                            state_q <= DRIVE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= RD_LAT_C;
                        end
                    end else if (bus.Write && hit) begin
                        state_q <= WACK;
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    // Leave once the count has run out; WAIT spans RD_LAT cycles.
                    if (cnt_q <= 3'd1) begin
                        state_q <= DRIVE;
                        ready_q <= 1'b1;
                    end
                end
                DRIVE: state_q <= IDLE;
                WACK:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Ready = ready_q;
    assign bus.Err   = err_q;

    // Only driver of the shared data lines; released the instant state leaves DRIVE.
    assign Data_Bus = (state_q == DRIVE) ? rd_dat : 32'hzzzz_zzzz;

endmodule
